// File: rtl/maze_pkg.sv
// Shared maze types: path rectangle table, goal rectangle, colours and game states.
package maze_pkg;

  typedef struct packed {
    logic [9:0] x0;
    logic [9:0] y0;
    logic [9:0] x1;
    logic [9:0] y1;
  } rect_t;

  typedef enum logic [1:0] {PLAY, HIT, WIN, OVER} state_t;

  // Path rectangles, half-open: x0 <= x < x1, y0 <= y < y1. Unused entries are empty.
  localparam rect_t MAZE_RECTS [16] = '{
    '{10'd40,  10'd47,  10'd200, 10'd80},
    '{10'd170, 10'd47,  10'd200, 10'd300},
    '{10'd170, 10'd270, 10'd400, 10'd300},
    '{10'd370, 10'd100, 10'd400, 10'd300},
    '{10'd370, 10'd100, 10'd600, 10'd130},
    '{10'd570, 10'd100, 10'd600, 10'd450},
    '{10'd300, 10'd420, 10'd600, 10'd450},
    '{10'd300, 10'd350, 10'd330, 10'd450},
    '{10'd0, 10'd0, 10'd0, 10'd0},
    '{10'd0, 10'd0, 10'd0, 10'd0},
    '{10'd0, 10'd0, 10'd0, 10'd0},
    '{10'd0, 10'd0, 10'd0, 10'd0},
    '{10'd0, 10'd0, 10'd0, 10'd0},
    '{10'd0, 10'd0, 10'd0, 10'd0},
    '{10'd0, 10'd0, 10'd0, 10'd0},
    '{10'd0, 10'd0, 10'd0, 10'd0}
  };

  // Goal sits inside the first corridor so it is always reachable over path.
  localparam rect_t GOAL_RECT = '{10'd100, 10'd47, 10'd130, 10'd80};

  // Colours packed as {red, green, blue}, 10 bits each.
  localparam logic [29:0] COL_PLAYER = {10'h3ff, 10'h3ff, 10'h000};
  localparam logic [29:0] COL_HIT    = {10'h3ff, 10'h000, 10'h000};
  localparam logic [29:0] COL_GOAL   = {10'h000, 10'h3ff, 10'h000};
  localparam logic [29:0] COL_PATH   = {10'h200, 10'h200, 10'h200};
  localparam logic [29:0] COL_WALL   = {10'h000, 10'h000, 10'h3ff};

  function automatic logic in_rect(input logic [9:0] px, input logic [9:0] py, input rect_t r);
    return (px >= r.x0) && (px < r.x1) && (py >= r.y0) && (py < r.y1);
  endfunction

endpackage

// File: rtl/maze_rect_hit.sv
// Reports whether a point lies in any of the first NUM_RECTS path rectangles.
module maze_rect_hit
  import maze_pkg::*;
#(
  parameter int NUM_RECTS = 8
) (
  input  logic [9:0] px,
  input  logic [9:0] py,
  output logic       hit
);

  // OR of the per-rectangle containment tests
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_RECTS; i++) begin
      if (in_rect(px, py, MAZE_RECTS[i])) hit = 1'b1;
    end
  end

endmodule

// File: rtl/maze_game_engine.sv
// Maze game: player square moved by buttons once per frame tick, wall collisions
// cost a life, goal detection, and registered pixel colour for the DAC.
module maze_game_engine
  import maze_pkg::*;
#(
  parameter int SQ_SIZE    = 15,
  parameter int START_X    = 55,
  parameter int START_Y    = 55,
  parameter int STEP       = 1,
  parameter int TICK_LINE  = 481,
  parameter int NUM_RECTS  = 8,
  parameter int LIVES      = 3,
  parameter int HIT_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       moveup,
  input  logic       movedown,
  input  logic       moveleft,
  input  logic       moveright,
  output logic [9:0] red,
  output logic [9:0] green,
  output logic [9:0] blue,
  output logic [2:0] lives_left,
  output logic       won,
  output logic       hit_pulse
);

  // flash_cnt needs bit 2 for the flash pattern even for tiny HIT_FRAMES
  localparam int FW = ($clog2(HIT_FRAMES + 1) < 3) ? 3 : $clog2(HIT_FRAMES + 1);

  localparam logic signed [10:0] STEP_S  = 11'(STEP);
  localparam logic signed [10:0] SQ_S    = 11'(SQ_SIZE);
  localparam logic [9:0]         SQ_W    = 10'(SQ_SIZE);
  localparam logic [9:0]         START_XW = 10'(START_X);
  localparam logic [9:0]         START_YW = 10'(START_Y);
  localparam logic [2:0]         LIVES_W = 3'(LIVES);
  localparam logic [FW-1:0]      HIT_W   = FW'(HIT_FRAMES);

  state_t          state, state_d;
  logic [9:0]      x1, y1;
  logic [FW-1:0]   flash_cnt;
  logic            armed;
  logic            refr_tick, any_btn, move_req;
  logic signed [10:0] cand_x, cand_y;
  logic [9:0]      cx_lo, cx_hi, cy_lo, cy_hi;
  logic [3:0]      corner_ok;
  logic            oob, legal, in_goal;
  logic            collide, commit, restart, arm;
  logic            square_on, pix_goal, pix_path;
  logic [29:0]     col_p0, rgb_p1;

  assign refr_tick = (y == 10'(TICK_LINE)) && (x == 10'd0);
  assign any_btn   = ~(moveup & movedown & moveleft & moveright);

  // Candidate position for this tick; priority up > down > left > right
  always_comb begin
    cand_x   = $signed({1'b0, x1});
    cand_y   = $signed({1'b0, y1});
    move_req = 1'b1;
    if (!moveup)         cand_y = cand_y - STEP_S;
    else if (!movedown)  cand_y = cand_y + STEP_S;
    else if (!moveleft)  cand_x = cand_x - STEP_S;
    else if (!moveright) cand_x = cand_x + STEP_S;
    else                 move_req = 1'b0;
  end

  assign cx_lo = cand_x[9:0] + 10'd1;
  assign cx_hi = cand_x[9:0] + SQ_W;
  assign cy_lo = cand_y[9:0] + 10'd1;
  assign cy_hi = cand_y[9:0] + SQ_W;

  maze_rect_hit #(.NUM_RECTS(NUM_RECTS)) u_c0 (.px(cx_lo), .py(cy_lo), .hit(corner_ok[0]));
  maze_rect_hit #(.NUM_RECTS(NUM_RECTS)) u_c1 (.px(cx_hi), .py(cy_lo), .hit(corner_ok[1]));
  maze_rect_hit #(.NUM_RECTS(NUM_RECTS)) u_c2 (.px(cx_lo), .py(cy_hi), .hit(corner_ok[2]));
  maze_rect_hit #(.NUM_RECTS(NUM_RECTS)) u_c3 (.px(cx_hi), .py(cy_hi), .hit(corner_ok[3]));

  // Negative candidate or far edge off-screen is a collision regardless of corners
  assign oob     = cand_x[10] || cand_y[10] ||
                   ((cand_x + SQ_S) >= 11'sd640) || ((cand_y + SQ_S) >= 11'sd480);
  assign legal   = !oob && (&corner_ok);
  // The goal is convex, so two opposite corners inside means the whole square is
  assign in_goal = in_rect(cx_lo, cy_lo, GOAL_RECT) && in_rect(cx_hi, cy_hi, GOAL_RECT);

  // Next-state and action decode, evaluated for use on the tick cycle
  always_comb begin
    state_d = state;
    collide = 1'b0;
    commit  = 1'b0;
    restart = 1'b0;
    arm     = 1'b0;
    case (state)
      PLAY: begin
        if (move_req) begin
          if (!legal) begin
            collide = 1'b1;
            state_d = (lives_left == 3'd1) ? OVER : HIT;
          end else begin
            commit = 1'b1;
            if (in_goal) state_d = WIN;
          end
        end
      end
      HIT: begin
        if (flash_cnt <= FW'(1)) state_d = PLAY;
      end
      WIN, OVER: begin
        if (armed && any_btn) begin
          restart = 1'b1;
          state_d = PLAY;
        end else if (!any_btn) begin
          arm = 1'b1;
        end
      end
      default: state_d = PLAY;
    endcase
  end

  // State register advances only on frame ticks
  always_ff @(posedge clk) begin
    if (reset)          state <= PLAY;
    else if (refr_tick) state <= state_d;
  end

  // Position, lives, flash counter, re-arm flag and the collision pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      x1         <= START_XW;
      y1         <= START_YW;
      lives_left <= LIVES_W;
      flash_cnt  <= '0;
      armed      <= 1'b0;
      hit_pulse  <= 1'b0;
    end else begin
      hit_pulse <= refr_tick && collide;
      if (refr_tick) begin
        if (collide) begin
          lives_left <= lives_left - 3'd1;
          x1         <= START_XW;
          y1         <= START_YW;
          flash_cnt  <= HIT_W;
        end
        if (commit) begin
          x1 <= cand_x[9:0];
          y1 <= cand_y[9:0];
        end
        if (state == HIT && flash_cnt != '0) flash_cnt <= flash_cnt - FW'(1);
        if (arm) armed <= 1'b1;
        if (restart) begin
          lives_left <= LIVES_W;
          x1         <= START_XW;
          y1         <= START_YW;
          armed      <= 1'b0;
        end
      end
    end
  end

  maze_rect_hit #(.NUM_RECTS(NUM_RECTS)) u_pix (.px(x), .py(y), .hit(pix_path));

  assign pix_goal  = in_rect(x, y, GOAL_RECT);
  assign square_on = ({1'b0, x} > {1'b0, x1}) && ({1'b0, x} <= ({1'b0, x1} + 11'(SQ_SIZE))) &&
                     ({1'b0, y} > {1'b0, y1}) && ({1'b0, y} <= ({1'b0, y1} + 11'(SQ_SIZE)));

  // Pixel colour selection by priority; background recoloured in WIN/OVER
  always_comb begin
    col_p0 = COL_WALL;
    if (square_on)     col_p0 = (state == HIT && flash_cnt[2]) ? COL_HIT : COL_PLAYER;
    else if (pix_goal) col_p0 = COL_GOAL;
    else if (pix_path) col_p0 = COL_PATH;
    else if (state == WIN)  col_p0 = COL_GOAL;
    else if (state == OVER) col_p0 = COL_HIT;
  end

  // Pixel stage boundary: one clock from (x,y) to DAC
  always_ff @(posedge clk) begin
    if (reset) rgb_p1 <= '0;
    else       rgb_p1 <= col_p0;
  end

  assign red   = rgb_p1[29:20];
  assign green = rgb_p1[19:10];
  assign blue  = rgb_p1[9:0];
  assign won   = (state == WIN);

endmodule

// File: tb/tb_maze_game_engine.sv
// Scoreboard bench for maze_game_engine: stimulus queues expectations, a monitor
// on the falling edge pops and compares them against the registered outputs.
module tb_maze_game_engine;
  import maze_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x, y;
  logic       moveup, movedown, moveleft, moveright;
  logic [9:0] red, green, blue;
  logic [2:0] lives_left;
  logic       won, hit_pulse;

  always #5 clk = ~clk;

  maze_game_engine dut (
    .clk(clk), .reset(reset), .x(x), .y(y),
    .moveup(moveup), .movedown(movedown), .moveleft(moveleft), .moveright(moveright),
    .red(red), .green(green), .blue(blue),
    .lives_left(lives_left), .won(won), .hit_pulse(hit_pulse)
  );

  localparam int K_RGB = 0, K_LIVES = 1, K_WON = 2, K_HIT = 3;
  localparam logic [3:0] B_NONE = 4'b0000, B_UP = 4'b1000, B_DN = 4'b0100,
                         B_LT = 4'b0010, B_RT = 4'b0001;

  typedef struct {
    string       name;
    int          kind;
    logic [29:0] val;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Monitor: compare every queued expectation against the outputs presented this cycle
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [29:0] act;
      e = q.pop_front();
      case (e.kind)
        K_RGB:   act = {red, green, blue};
        K_LIVES: act = {27'd0, lives_left};
        K_WON:   act = {29'd0, won};
        default: act = {29'd0, hit_pulse};
      endcase
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic expect_v(input string n, input int k, input logic [29:0] v);
    exp_t e;
    e.name = n; e.kind = k; e.val = v;
    q.push_back(e);
  endtask

  task automatic cyc(input logic [9:0] xv, input logic [9:0] yv);
    x = xv; y = yv;
    @(posedge clk); #1;
  endtask

  task automatic tick(input logic [3:0] b);
    moveup = ~b[3]; movedown = ~b[2]; moveleft = ~b[1]; moveright = ~b[0];
    cyc(10'd0, 10'd481);
  endtask

  task automatic ticks(input int n, input logic [3:0] b);
    repeat (n) tick(b);
  endtask

  task automatic probe(input string n, input logic [9:0] px, input logic [9:0] py,
                       input logic [29:0] col);
    cyc(px, py);
    expect_v(n, K_RGB, col);
  endtask

  initial begin
    reset = 1'b1;
    moveup = 1'b1; movedown = 1'b1; moveleft = 1'b1; moveright = 1'b1;
    x = '0; y = '0;
    cyc(10'd0, 10'd0);
    cyc(10'd56, 10'd56);
    expect_v("reset rgb", K_RGB, 30'd0);
    expect_v("reset lives", K_LIVES, 30'd3);
    expect_v("reset won", K_WON, 30'd0);
    expect_v("reset hit_pulse", K_HIT, 30'd0);
    reset = 1'b0;

    // 1: idle frames, square at start
    ticks(3, B_NONE);
    probe("t1 square", 10'd56, 10'd56, COL_PLAYER);
    probe("t1 left of square", 10'd55, 10'd56, COL_PATH);
    probe("t1 wall", 10'd10, 10'd10, COL_WALL);
    probe("t1 goal", 10'd110, 10'd60, COL_GOAL);
    expect_v("t1 lives", K_LIVES, 30'd3);

    // 2: ten steps right -> x1=65
    for (int i = 0; i < 10; i++) begin
      tick(B_RT);
      expect_v("t2 no hit", K_HIT, 30'd0);
    end
    probe("t2 sq left edge", 10'd66, 10'd56, COL_PLAYER);
    probe("t2 vacated", 10'd65, 10'd56, COL_PATH);
    probe("t2 sq far corner", 10'd80, 10'd70, COL_PLAYER);
    probe("t2 right of sq", 10'd81, 10'd56, COL_PATH);

    // 3: up to y1=46 is legal, next up hits the wall above y=47
    ticks(9, B_UP);
    probe("t3 top row", 10'd66, 10'd47, COL_PLAYER);
    probe("t3 wall above", 10'd66, 10'd46, COL_WALL);
    tick(B_UP);
    expect_v("t3 hit_pulse", K_HIT, 30'd1);
    expect_v("t3 lives", K_LIVES, 30'd2);
    probe("t3 flash at start", 10'd56, 10'd56, COL_HIT);
    expect_v("t3 pulse one clk", K_HIT, 30'd0);
    ticks(26, B_UP);
    probe("t3 flash cnt4", 10'd56, 10'd56, COL_HIT);
    tick(B_UP);
    probe("t3 flash cnt3", 10'd56, 10'd56, COL_PLAYER);
    ticks(2, B_UP);
    probe("t3 no move in hit", 10'd56, 10'd70, COL_PLAYER);
    tick(B_UP);
    probe("t3 back to play", 10'd56, 10'd70, COL_PLAYER);
    tick(B_UP);
    probe("t3 moved up vacated", 10'd56, 10'd70, COL_PATH);
    probe("t3 moved up", 10'd56, 10'd55, COL_PLAYER);

    // 4: two more collisions -> OVER, re-arm then restart
    ticks(8, B_UP);
    tick(B_UP);
    expect_v("t4 lives 1", K_LIVES, 30'd1);
    ticks(30, B_NONE);
    ticks(9, B_UP);
    tick(B_UP);
    expect_v("t4 lives 0", K_LIVES, 30'd0);
    expect_v("t4 last hit", K_HIT, 30'd1);
    expect_v("t4 won low", K_WON, 30'd0);
    probe("t4 over wall", 10'd10, 10'd10, COL_HIT);
    probe("t4 over path", 10'd150, 10'd60, COL_PATH);
    probe("t4 over square", 10'd56, 10'd56, COL_PLAYER);
    ticks(2, B_UP);
    expect_v("t4 held no restart", K_LIVES, 30'd0);
    probe("t4 still over", 10'd10, 10'd10, COL_HIT);
    tick(B_NONE);
    expect_v("t4 armed only", K_LIVES, 30'd0);
    tick(B_RT);
    expect_v("t4 restart lives", K_LIVES, 30'd3);
    probe("t4 wall normal", 10'd10, 10'd10, COL_WALL);
    probe("t4 start pos", 10'd56, 10'd56, COL_PLAYER);
    probe("t4 no move on restart", 10'd71, 10'd56, COL_PATH);

    // 5: walk right into the goal (x1=99)
    ticks(43, B_RT);
    expect_v("t5 not yet won", K_WON, 30'd0);
    tick(B_RT);
    expect_v("t5 won", K_WON, 30'd1);
    probe("t5 win wall", 10'd10, 10'd10, COL_GOAL);
    probe("t5 square in goal", 10'd100, 10'd56, COL_PLAYER);
    ticks(2, B_RT);
    expect_v("t5 held stays won", K_WON, 30'd1);
    probe("t5 no move in win", 10'd115, 10'd56, COL_GOAL);
    tick(B_NONE);
    expect_v("t5 armed still won", K_WON, 30'd1);
    tick(B_LT);
    expect_v("t5 restart won", K_WON, 30'd0);
    expect_v("t5 restart lives", K_LIVES, 30'd3);
    probe("t5 restart pos", 10'd56, 10'd56, COL_PLAYER);

    // 6: reset on a tick cycle in the middle of HIT
    ticks(9, B_UP);
    tick(B_UP);
    expect_v("t6 lives 2", K_LIVES, 30'd2);
    ticks(5, B_NONE);
    reset = 1'b1;
    tick(B_UP);
    expect_v("t6 reset lives", K_LIVES, 30'd3);
    expect_v("t6 reset rgb", K_RGB, 30'd0);
    expect_v("t6 reset pulse", K_HIT, 30'd0);
    reset = 1'b0;
    tick(4'b1111);
    probe("t6 up wins priority", 10'd56, 10'd55, COL_PLAYER);
    tick(4'b0111);
    probe("t6 down over lr", 10'd56, 10'd70, COL_PLAYER);
    probe("t6 down vacated", 10'd56, 10'd55, COL_PATH);
    tick(4'b0011);
    probe("t6 left over right", 10'd55, 10'd56, COL_PLAYER);
    tick(B_RT);
    probe("t6 right", 10'd70, 10'd56, COL_PLAYER);
    probe("t6 right vacated", 10'd55, 10'd56, COL_PATH);

    @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
